// File: rtl/game_option_selector.sv
// game_option_selector: two debounced push-buttons step a
// one-hot option register, wrapping or saturating at the ends.
module gos_btn_stage #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          lvl_q;
  logic          lvl_d;
  logic          hist_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // synchroniser, debounced level, counter and edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      hist_q <= lvl_q;
    end
  end

  // accept a new level only after it persisted the full window
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CMAX) lvl_d = sync_q[1];
      else cnt_d = cnt_q + 1'b1;
    end
  end

  assign press = lvl_q & ~hist_q;
endmodule

module game_option_selector #(
  parameter int N_OPTIONS       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit WRAP            = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         btn_next,
  input  logic                         btn_prev,
  input  logic                         lock,
  output logic [N_OPTIONS-1:0]         option_onehot,
  output logic [$clog2(N_OPTIONS)-1:0] option_index,
  output logic                         option_valid,
  output logic                         change_pulse
);
  localparam int IW = $clog2(N_OPTIONS);
  localparam logic [IW-1:0] LAST = IW'(N_OPTIONS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEL  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          pulse_q;
  logic          nxt_ev;
  logic          prv_ev;
  logic          chg;

  gos_btn_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (btn_next),
    .press  (nxt_ev)
  );

  gos_btn_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_prev (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (btn_prev),
    .press  (prv_ev)
  );

  assign chg = (state_d != state_q) || (idx_d != idx_q);

  // selection state, index and change strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= chg;
    end
  end

  // act only on a lone, unlocked press event
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!lock && (nxt_ev ^ prv_ev)) begin
      unique case (1'b1)
        (state_q == IDLE) && nxt_ev: begin
          state_d = SEL;
          idx_d   = '0;
        end
        (state_q == IDLE) && prv_ev: begin
          state_d = SEL;
          idx_d   = LAST;
        end
        (state_q == SEL) && nxt_ev && (idx_q != LAST):
          idx_d = idx_q + 1'b1;
        (state_q == SEL) && nxt_ev && (idx_q == LAST):
          if (WRAP) idx_d = '0;
        (state_q == SEL) && prv_ev && (idx_q != '0):
          idx_d = idx_q - 1'b1;
        (state_q == SEL) && prv_ev && (idx_q == '0):
          if (WRAP) idx_d = LAST;
        default: ;
      endcase
    end
  end

  // decode registered state to the output views
  always_comb begin
    option_onehot = '0;
    if (state_q == SEL) option_onehot[idx_q] = 1'b1;
    option_index = idx_q;
    option_valid = (state_q == SEL);
    change_pulse = pulse_q;
  end
endmodule

// File: tb/tb_game_option_selector.sv
// tb_game_option_selector: table vectors plus pulse scoreboard
// on a wrapping and a saturating instance fed the same buttons.
module tb_game_option_selector;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_next;
  logic       btn_prev;
  logic       lock;
  logic [3:0] oh_w, oh_s;
  logic [1:0] ix_w, ix_s;
  logic       v_w, v_s, cp_w, cp_s;

  int checks = 0;
  int errors = 0;
  int pw = 0;
  int ps = 0;
  logic [3:0] qw[$];
  logic [3:0] qs[$];
  logic [3:0] cur_w, cur_s;

  typedef struct {
    bit         nxt;
    bit         prv;
    bit         lk;
    int         hi;
    logic [3:0] ew;
    logic [3:0] es;
  } vec_t;
  vec_t vt[16];

  always #5 clk = ~clk;

  game_option_selector #(
    .N_OPTIONS(4), .DEBOUNCE_CYCLES(4), .WRAP(1'b1)
  ) dut_w (
    .clk(clk), .reset_n(reset_n),
    .btn_next(btn_next), .btn_prev(btn_prev), .lock(lock),
    .option_onehot(oh_w), .option_index(ix_w),
    .option_valid(v_w), .change_pulse(cp_w)
  );

  game_option_selector #(
    .N_OPTIONS(4), .DEBOUNCE_CYCLES(4), .WRAP(1'b0)
  ) dut_s (
    .clk(clk), .reset_n(reset_n),
    .btn_next(btn_next), .btn_prev(btn_prev), .lock(lock),
    .option_onehot(oh_s), .option_index(ix_s),
    .option_valid(v_s), .change_pulse(cp_s)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string t,
                             input logic [3:0] ew,
                             input logic [3:0] es);
    chk({t, "_w_onehot"}, oh_w, ew);
    chk({t, "_w_index"}, ix_w, idx_of(ew));
    chk({t, "_w_valid"}, v_w, |ew);
    chk({t, "_s_onehot"}, oh_s, es);
    chk({t, "_s_index"}, ix_s, idx_of(es));
    chk({t, "_s_valid"}, v_s, |es);
  endtask

  task automatic drive(input bit n, input bit p,
                       input bit lk, input int hi);
    btn_next = n;
    btn_prev = p;
    lock     = lk;
    for (int c = 0; c < hi; c++) begin
      step();
      if (lk && c == 9) lock = 1'b0;
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    lock     = 1'b0;
    repeat (14) step();
  endtask

  task automatic wait_pulse(input string nm, input int exp_k);
    int k;
    k = 0;
    while (k < 30) begin
      step();
      k++;
      if (cp_w) break;
    end
    chk({nm, "_w_edges"}, k, exp_k);
    chk({nm, "_s_pulse"}, cp_s, 1);
  endtask

  // scoreboard: every strobe must match the next queued selection
  always @(negedge clk) begin
    if (reset_n) begin
      if (cp_w) begin
        pw++;
        if (qw.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_pulse: unexpected strobe, onehot %b", oh_w);
        end else chk("w_pulse_onehot", oh_w, qw.pop_front());
      end
      if (cp_s) begin
        ps++;
        if (qs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_pulse: unexpected strobe, onehot %b", oh_s);
        end else chk("s_pulse_onehot", oh_s, qs.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int pw0, ps0;
    vt[0]  = '{1'b1, 1'b0, 1'b0, 10, 4'b0010, 4'b0010};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 10, 4'b0100, 4'b0100};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 10, 4'b1000, 4'b1000};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 10, 4'b0001, 4'b1000};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 10, 4'b1000, 4'b0100};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 10, 4'b0100, 4'b0010};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 10, 4'b0010, 4'b0001};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 10, 4'b0001, 4'b0001};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 10, 4'b1000, 4'b0001};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1,  4'b1000, 4'b0001};
    vt[10] = '{1'b1, 1'b0, 1'b0, 2,  4'b1000, 4'b0001};
    vt[11] = '{1'b1, 1'b0, 1'b0, 3,  4'b1000, 4'b0001};
    vt[12] = '{1'b1, 1'b0, 1'b0, 4,  4'b0001, 4'b0010};
    vt[13] = '{1'b1, 1'b0, 1'b1, 14, 4'b0001, 4'b0010};
    vt[14] = '{1'b1, 1'b0, 1'b0, 10, 4'b0010, 4'b0100};
    vt[15] = '{1'b1, 1'b1, 1'b0, 10, 4'b0010, 4'b0100};

    reset_n  = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    lock     = 1'b0;
    repeat (3) step();
    check_state("reset", 4'b0000, 4'b0000);
    chk("reset_w_pulse", cp_w, 0);
    chk("reset_s_pulse", cp_s, 0);
    reset_n = 1'b1;
    repeat (2) step();

    pw0 = pw;
    ps0 = ps;
    qw.push_back(4'b0001);
    qs.push_back(4'b0001);
    btn_next = 1'b1;
    wait_pulse("lat_first", 7);
    repeat (3) step();
    btn_next = 1'b0;
    repeat (14) step();
    check_state("first", 4'b0001, 4'b0001);
    chk("first_w_pulses", pw - pw0, 1);
    chk("first_s_pulses", ps - ps0, 1);
    cur_w = 4'b0001;
    cur_s = 4'b0001;

    for (int i = 0; i < 16; i++) begin
      pw0 = pw;
      ps0 = ps;
      if (vt[i].ew != cur_w) qw.push_back(vt[i].ew);
      if (vt[i].es != cur_s) qs.push_back(vt[i].es);
      drive(vt[i].nxt, vt[i].prv, vt[i].lk, vt[i].hi);
      check_state($sformatf("v%0d", i), vt[i].ew, vt[i].es);
      chk($sformatf("v%0d_w_pulses", i), pw - pw0,
          (vt[i].ew != cur_w) ? 1 : 0);
      chk($sformatf("v%0d_s_pulses", i), ps - ps0,
          (vt[i].es != cur_s) ? 1 : 0);
      cur_w = vt[i].ew;
      cur_s = vt[i].es;
    end

    pw0 = pw;
    ps0 = ps;
    qw.push_back(4'b0100);
    qw.push_back(4'b0010);
    qs.push_back(4'b1000);
    qs.push_back(4'b0100);
    btn_next = 1'b1;
    repeat (2) step();
    btn_prev = 1'b1;
    repeat (8) step();
    btn_next = 1'b0;
    repeat (2) step();
    btn_prev = 1'b0;
    repeat (14) step();
    check_state("stagger", 4'b0010, 4'b0100);
    chk("stagger_w_pulses", pw - pw0, 2);
    chk("stagger_s_pulses", ps - ps0, 2);

    qw.push_back(4'b0100);
    qs.push_back(4'b1000);
    drive(1'b1, 1'b0, 1'b0, 10);
    check_state("to_idx2", 4'b0100, 4'b1000);

    btn_next = 1'b1;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check_state("async_rst", 4'b0000, 4'b0000);
    chk("async_rst_w_pulse", cp_w, 0);
    chk("async_rst_s_pulse", cp_s, 0);
    repeat (3) step();
    reset_n = 1'b1;
    pw0 = pw;
    ps0 = ps;
    qw.push_back(4'b0001);
    qs.push_back(4'b0001);
    wait_pulse("lat_post_rst", 7);
    repeat (5) step();
    btn_next = 1'b0;
    repeat (14) step();
    check_state("post_rst", 4'b0001, 4'b0001);
    chk("post_rst_w_pulses", pw - pw0, 1);
    chk("post_rst_s_pulses", ps - ps0, 1);

    chk("queue_w_left", qw.size(), 0);
    chk("queue_s_left", qs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/game_option_selector.md
# game_option_selector

Parametrised, clocked selector for the active game option. It takes two raw push-buttons (next/previous) and passes each through a synchroniser, a debounce filter and a rising-edge detector. It then steps a one-hot option register through N options, with wrap or saturate at the ends. It sits between the board buttons and the game-dispatch logic, and supersedes the unclocked single-button rotator.

## Interface

Parameters:
- N_OPTIONS, 4, number of selectable options; legal range ≥ 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles required before a button level is accepted; legal range ≥ 1.
- WRAP, 1, end behaviour: 1 = wrap-around, 0 = saturate at the first/last option.

Ports (IW = max(1, clog2(N_OPTIONS))):
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_next  input  1  raw, asynchronous, active-high "next option" button.
- btn_prev  input  1  raw, asynchronous, active-high "previous option" button.
- lock  input  1  synchronous; when high, press events are discarded (not queued).
- option_onehot  output  N_OPTIONS  selected option, one-hot; all zero = no option selected.
- option_index  output  IW  binary index of the selected option; 0 when no option is selected.
- option_valid  output  1  high once an option has been selected.
- change_pulse  output  1  one-cycle strobe in the cycle the selection changes.

## Operation

- Per button: a 2-flop synchroniser, then a debounce filter, then a rising-edge detector.
- Debounce filter:
  - Holds a debounced level and a counter.
  - When the synchronised level differs from the debounced level, the counter increments.
  - Once the difference has persisted for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears.
  - Any cycle where the two levels agree clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press event: the debounced level rises from 0 to 1. A release produces no event.
- Selection state machine has two states:
  - IDLE: valid = 0, onehot = 0.
  - SELECTED: valid = 1, onehot = 1 << index.
- Transitions, evaluated only when lock = 0 and exactly one press event is present:
  - IDLE + next → SELECTED, index 0.
  - IDLE + prev → SELECTED, index N_OPTIONS-1.
  - SELECTED + next:
    - index < N-1 → index+1.
    - index = N-1 → 0 if WRAP = 1; otherwise hold.
  - SELECTED + prev:
    - index > 0 → index-1.
    - index = 0 → N-1 if WRAP = 1; otherwise hold.
- Simultaneous next and prev events in the same cycle → both ignored; no change and no pulse.
- lock = 1 → events in that cycle are dropped. Releasing lock does not replay them. The debounce and synchroniser chains keep running while locked.
- change_pulse asserts only when the index or the state actually changes. A saturated hold gives no pulse.
- SELECTED is never left except by reset.
- option_onehot always has at most one bit set; an out-of-range index is unreachable.

## Timing

- Reset (reset_n low, asynchronously, including mid-debounce or mid-press):
  - option_onehot = 0, option_index = 0, option_valid = 0, change_pulse = 0.
  - Synchroniser flops, debounced levels, edge-detector history and counters all clear to 0.
  - A button still held when reset releases is treated as a fresh rising input and produces one event after full debounce.
- Latency: raw input rises and stays stable → the selection register and change_pulse update at rising edge 2 + DEBOUNCE_CYCLES + 1 after the first edge that samples the high level. Breakdown: 2 synchroniser edges, DEBOUNCE_CYCLES filter edges, 1 edge-detect/update edge.
- Outputs are registered, with no combinational path from inputs.
- change_pulse is exactly one cycle wide.
- At most one selection change per press. Holding a button never auto-repeats.

## Test plan

Parameters N_OPTIONS = 4, DEBOUNCE_CYCLES = 4, WRAP = 1 unless stated.

- Reset, then four clean btn_next presses, each held 10 cycles → onehot 0001, 0010, 0100, 1000. Index 0..3, valid rises on the first press, one change_pulse per press, each update exactly 7 edges after the press.
- From index 3, one more btn_next → onehot 0001 (wrap). From index 0, btn_prev → 1000. With WRAP = 0, the same stimulus holds the index and gives no change_pulse.
- Glitches on btn_next of 1, 2 and 3 cycles separated by ≥ 1 low cycle → no change. A 4-cycle stable high → exactly one advance.
- btn_next and btn_prev raised on the same edge with identical bounce → no change and no pulse. Staggered by 2 cycles → both events apply in order, net index unchanged, 2 pulses.
- lock high during a next press, released afterwards while the button is still held → no change. A subsequent new press advances normally.
- reset_n asserted mid-debounce while at index 2 → outputs go 0 immediately (asynchronously). Button held through the reset release → a single event selects index 0.
